// File: rtl/uart_baud_gen_frac.sv
// rtl/uart_baud_gen_frac.sv - fractional baud tick generator with selectable oversampling and resync
module uart_baud_gen_frac #(
    parameter int         DIV_W        = 16,
    parameter int         FRAC_W       = 4,
    parameter int         RST_DIV_INT  = 175,
    parameter int         RST_DIV_FRAC = 12,
    parameter logic [1:0] RST_OSR_SEL  = 2'b00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic [1:0]        osr_sel,
    input  logic              resync,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic              cfg_err
);

    logic [DIV_W-1:0]  div_q;
    logic [FRAC_W-1:0] frac_q;
    logic [1:0]        osr_q;
    logic [DIV_W:0]    cnt;
    logic [FRAC_W-1:0] acc;
    logic [3:0]        os_cnt;

    logic [FRAC_W:0]   acc_sum;
    logic [DIV_W:0]    len_m1;
    logic [3:0]        os_last;
    logic [3:0]        os_mid;
    logic              period_end;
    logic              load_ok;
    logic              restart;

    // The carry out of the fractional accumulator stretches this period by one cycle.
    assign acc_sum    = {1'b0, acc} + {1'b0, frac_q};
    assign len_m1     = {1'b0, div_q} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]} - (DIV_W+1)'(1);
    assign period_end = (cnt == len_m1);

    always_comb begin
        os_last = 4'd15;
        os_mid  = 4'd7;
        case (osr_q)
            2'b01: begin
                os_last = 4'd12;
                os_mid  = 4'd5;
            end
            2'b10: begin
                os_last = 4'd7;
                os_mid  = 4'd3;
            end
            default: begin
                os_last = 4'd15;
                os_mid  = 4'd7;
            end
        endcase
    end

    assign load_ok = cfg_load && (div_int >= DIV_W'(2));
    // An illegal load still restarts when resync arrives in the same cycle.
    assign restart = load_ok || resync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= DIV_W'(RST_DIV_INT);
            frac_q   <= FRAC_W'(RST_DIV_FRAC);
            osr_q    <= RST_OSR_SEL;
            cnt      <= '0;
            acc      <= '0;
            os_cnt   <= '0;
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            if (cfg_load) begin
                if (load_ok) begin
                    div_q   <= div_int;
                    frac_q  <= div_frac;
                    osr_q   <= osr_sel;
                    cfg_err <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
            if (restart) begin
                cnt      <= '0;
                acc      <= '0;
                os_cnt   <= '0;
                os_tick  <= 1'b0;
                mid_tick <= 1'b0;
                bit_tick <= 1'b0;
            end else if (en) begin
                if (period_end) begin
                    cnt      <= '0;
                    acc      <= acc_sum[FRAC_W-1:0];
                    os_tick  <= 1'b1;
                    mid_tick <= (os_cnt == os_mid);
                    bit_tick <= (os_cnt == os_last);
                    os_cnt   <= (os_cnt == os_last) ? 4'd0 : os_cnt + 4'd1;
                end else begin
                    cnt      <= cnt + (DIV_W+1)'(1);
                    os_tick  <= 1'b0;
                    mid_tick <= 1'b0;
                    bit_tick <= 1'b0;
                end
            end else begin
                os_tick  <= 1'b0;
                mid_tick <= 1'b0;
                bit_tick <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// tb/tb_uart_baud_gen_frac.sv - randomized and directed checks of uart_baud_gen_frac against a period-based model
module tb_uart_baud_gen_frac;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        cfg_load = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic [1:0]  osr_sel = '0;
    logic        resync = 1'b0;
    logic        os_tick, mid_tick, bit_tick, cfg_err;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: period k since restart lasts div + (floor((k+1)f/16) - floor(kf/16)).
    int m_div, m_frac, m_osr, m_k, m_el;
    bit m_err, e_os, e_mid, e_bit;

    uart_baud_gen_frac dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .cfg_load (cfg_load),
        .div_int  (div_int),
        .div_frac (div_frac),
        .osr_sel  (osr_sel),
        .resync   (resync),
        .os_tick  (os_tick),
        .mid_tick (mid_tick),
        .bit_tick (bit_tick),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic int osr_of(input logic [1:0] s);
        return (s == 2'b01) ? 13 : (s == 2'b10) ? 8 : 16;
    endfunction

    function automatic int extra_cycles(input int k);
        int r;
        r = k % 16;
        return ((r + 1) * m_frac) / 16 - (r * m_frac) / 16;
    endfunction

    task automatic model_reset();
        m_div = 175; m_frac = 12; m_osr = 16; m_err = 0;
        m_k = 0; m_el = 0;
        e_os = 0; e_mid = 0; e_bit = 0;
    endtask

    task automatic model_clock();
        bit rs;
        rs = resync;
        e_os = 0; e_mid = 0; e_bit = 0;
        if (cfg_load) begin
            if (div_int >= 2) begin
                m_div = div_int; m_frac = div_frac; m_osr = osr_of(osr_sel);
                m_err = 0; rs = 1;
            end else begin
                m_err = 1;
            end
        end
        if (rs) begin
            m_k = 0; m_el = 0;
        end else if (en) begin
            m_el++;
            if (m_el == m_div + extra_cycles(m_k)) begin
                e_os  = 1;
                e_bit = (m_k % m_osr) == m_osr - 1;
                e_mid = (m_k % m_osr) == m_osr / 2 - 1;
                m_k++;
                m_el = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_clock();
        #1;
        check_val("os_mid_bit_err", {28'd0, os_tick, mid_tick, bit_tick, cfg_err},
                  {28'd0, e_os, e_mid, e_bit, m_err});
    endtask

    task automatic run_until(input int which, input int budget, output int n);
        bit hit;
        n = 0; hit = 0;
        while (!hit && n < budget) begin
            step();
            n++;
            hit = (which == 0) ? (os_tick === 1'b1) : (which == 1) ? (mid_tick === 1'b1) : (bit_tick === 1'b1);
        end
        if (!hit) check_val("tick_timeout", 0, 1);
    endtask

    task automatic load(input int di, input int df, input logic [1:0] os);
        div_int = 16'(di); div_frac = 4'(df); osr_sel = os; cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    initial begin
        int n, n2;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        en = 1'b1;

        run_until(0, 400, n);   check_val("first_os_default", n, 175);
        run_until(2, 4000, n);
        run_until(2, 4000, n);  check_val("bit_period_default", n, 2812);

        load(4, 0, 2'b00);
        run_until(2, 200, n);   check_val("bit_after_load_x16", n, 64);
        run_until(1, 200, n);   check_val("mid_after_bit_x16", n, 32);
        run_until(2, 200, n);   check_val("bit_after_mid_x16", n, 32);

        load(4, 8, 2'b00);
        run_until(2, 200, n);   check_val("bit_frac8_first", n, 72);
        run_until(2, 200, n);   check_val("bit_frac8_second", n, 72);

        load(3, 0, 2'b01);
        run_until(1, 200, n);   check_val("mid_x13", n, 18);
        run_until(2, 200, n);   check_val("bit_after_mid_x13", n, 21);
        run_until(2, 200, n);   check_val("bit_period_x13", n, 39);

        load(4, 0, 2'b00);
        repeat (10) step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        run_until(0, 50, n);    check_val("os_after_resync", n, 4);
        run_until(2, 200, n2);  check_val("bit_after_resync", n + n2, 64);

        load(1, 0, 2'b00);
        check_val("cfg_err_set", cfg_err, 1);
        run_until(0, 50, n);
        run_until(0, 50, n);    check_val("os_after_illegal", n, 4);
        load(5, 0, 2'b00);
        check_val("cfg_err_clear", cfg_err, 0);
        run_until(0, 50, n);    check_val("os_div5_first", n, 5);
        run_until(0, 50, n);    check_val("os_div5_second", n, 5);
        repeat (2) step();
        en = 1'b0;
        repeat (20) step();
        en = 1'b1;
        run_until(0, 50, n);    check_val("os_resume_after_hold", n, 3);

        run_until(0, 50, n);
        rst_n = 1'b0;
        #1;
        check_val("async_reset_outputs", {28'd0, os_tick, mid_tick, bit_tick, cfg_err}, 0);
        repeat (2) step();
        rst_n = 1'b1;
        run_until(0, 400, n);   check_val("first_os_after_reset", n, 175);

        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 199);
            en       = ($urandom_range(0, 9) != 0);
            cfg_load = (r < 3) || (r == 6);
            resync   = (r >= 3 && r <= 6);
            div_int  = 16'($urandom_range(0, 7));
            div_frac = 4'($urandom);
            osr_sel  = 2'($urandom);
            step();
        end
        cfg_load = 1'b0;
        resync = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
